// File: rtl/cu_pkg.sv
// Shared definitions for the accumulator-machine control sequencer:
// opcodes, FSM state encoding and the bit map of the one-hot ALU control vector.
package cu_pkg;

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_STORE  = 8'h01;
  localparam logic [7:0] OP_LOAD   = 8'h02;
  localparam logic [7:0] OP_ADD    = 8'h03;
  localparam logic [7:0] OP_SUB    = 8'h04;
  localparam logic [7:0] OP_JMPGEZ = 8'h05;
  localparam logic [7:0] OP_JMP    = 8'h06;
  localparam logic [7:0] OP_HALT   = 8'h07;
  localparam logic [7:0] OP_MPY    = 8'h08;
  localparam logic [7:0] OP_JZ     = 8'h09;
  localparam logic [7:0] OP_AND    = 8'h0A;
  localparam logic [7:0] OP_OR     = 8'h0B;
  localparam logic [7:0] OP_NOT    = 8'h0C;
  localparam logic [7:0] OP_SHR    = 8'h0D;
  localparam logic [7:0] OP_SHL    = 8'h0E;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_OPFETCH,
    ST_EXEC,
    ST_STORE,
    ST_HALT
  } state_t;

  // Position of each ALU control line inside the 10-bit one-hot vector.
  localparam int C8_IDX  = 0;
  localparam int C9_IDX  = 1;
  localparam int C13_IDX = 2;
  localparam int C15_IDX = 3;
  localparam int C16_IDX = 4;
  localparam int C17_IDX = 5;
  localparam int C18_IDX = 6;
  localparam int C19_IDX = 7;
  localparam int C20_IDX = 8;
  localparam int C21_IDX = 9;
  localparam int ALU_W   = 10;

  // ALUflags bit positions, packed as {ZF,CF,OF,SF}.
  localparam int FLAG_ZF = 3;
  localparam int FLAG_SF = 0;

endpackage

// File: rtl/cu_decode.sv
// Combinational opcode decoder: classifies the instruction and selects the
// single ALU control line it will pulse in EXEC.
module cu_decode
  import cu_pkg::*;
(
  input  logic [7:0]       opcode,
  output logic [ALU_W-1:0] alu_onehot,
  output logic             needs_operand,
  output logic             is_jump,
  output logic             is_cond,
  output logic             is_store,
  output logic             is_halt,
  output logic             illegal
);

  always_comb begin
    alu_onehot    = '0;
    needs_operand = 1'b0;
    is_jump       = 1'b0;
    is_cond       = 1'b0;
    is_store      = 1'b0;
    is_halt       = 1'b0;
    illegal       = 1'b0;
    case (opcode)
      OP_NOP:    ;
      OP_STORE:  is_store = 1'b1;
      OP_LOAD:   begin alu_onehot[C20_IDX] = 1'b1; needs_operand = 1'b1; end
      OP_ADD:    begin alu_onehot[C8_IDX]  = 1'b1; needs_operand = 1'b1; end
      OP_SUB:    begin alu_onehot[C9_IDX]  = 1'b1; needs_operand = 1'b1; end
      OP_JMPGEZ: begin is_jump = 1'b1; is_cond = 1'b1; end
      OP_JMP:    is_jump = 1'b1;
      OP_HALT:   is_halt = 1'b1;
      OP_MPY:    begin alu_onehot[C19_IDX] = 1'b1; needs_operand = 1'b1; end
      OP_JZ:     begin is_jump = 1'b1; is_cond = 1'b1; end
      OP_AND:    begin alu_onehot[C13_IDX] = 1'b1; needs_operand = 1'b1; end
      OP_OR:     begin alu_onehot[C15_IDX] = 1'b1; needs_operand = 1'b1; end
      // Accumulator-only operations go straight to EXEC.
      OP_NOT:    alu_onehot[C16_IDX] = 1'b1;
      OP_SHR:    alu_onehot[C18_IDX] = 1'b1;
      OP_SHL:    alu_onehot[C17_IDX] = 1'b1;
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Microsequenced control unit for the accumulator/ALU datapath: fetches and
// decodes instructions, runs the memory handshake and pulses one ALU line per EXEC.
module control_sequencer
  import cu_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] ACC_in,
  input  logic [3:0]        ALUflags,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] IR_out,
  output logic [DATA_W-1:0] BR_out,
  output logic              C8,
  output logic              C9,
  output logic              C13,
  output logic              C15,
  output logic              C16,
  output logic              C17,
  output logic              C18,
  output logic              C19,
  output logic              C20,
  output logic              C21,
  output logic [ADDR_W-1:0] pc_out,
  output logic              halted,
  output logic              illegal
);

  localparam logic [ADDR_W-1:0] PC_ONE = 1;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] br;
  logic [ALU_W-1:0]  alu;

  logic [ALU_W-1:0]  alu_onehot;
  logic              needs_operand;
  logic              is_jump;
  logic              is_cond;
  logic              is_store;
  logic              is_halt;
  logic              dec_illegal;

  logic [7:0]        opcode;
  logic [ADDR_W-1:0] x;
  logic              jump_taken;
  logic              unused_flags;

  assign opcode = ir[DATA_W-1 -: 8];
  assign x      = ir[ADDR_W-1:0];

  // JZ tests ZF; JMPGEZ is taken while the accumulator is non-negative (SF=0).
  assign jump_taken = !is_cond ||
                      ((opcode == OP_JZ) ? ALUflags[FLAG_ZF] : !ALUflags[FLAG_SF]);
  assign unused_flags = ^ALUflags[2:1];

  cu_decode u_decode (
    .opcode        (opcode),
    .alu_onehot    (alu_onehot),
    .needs_operand (needs_operand),
    .is_jump       (is_jump),
    .is_cond       (is_cond),
    .is_store      (is_store),
    .is_halt       (is_halt),
    .illegal       (dec_illegal)
  );

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state     <= ST_IDLE;
      pc        <= '0;
      ir        <= '0;
      br        <= '0;
      alu       <= '0;
      mem_addr  <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_wdata <= '0;
      halted    <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      // C lines are single-cycle pulses; only the EXEC entry below raises one.
      alu <= '0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            pc       <= '0;
            mem_addr <= '0;
            mem_rd   <= 1'b1;
            state    <= ST_FETCH;
          end
        end

        ST_FETCH: begin
          if (mem_ready) begin
            ir     <= mem_rdata;
            pc     <= pc + PC_ONE;
            mem_rd <= 1'b0;
            state  <= ST_DECODE;
          end
        end

        ST_DECODE: begin
          if (is_halt || dec_illegal) begin
            halted  <= 1'b1;
            illegal <= illegal | dec_illegal;
            state   <= ST_HALT;
          end else if (is_store) begin
            mem_wr    <= 1'b1;
            mem_addr  <= x;
            mem_wdata <= ACC_in;
            state     <= ST_STORE;
          end else if (is_jump) begin
            mem_rd   <= 1'b1;
            mem_addr <= jump_taken ? x : pc;
            if (jump_taken) pc <= x;
            state    <= ST_FETCH;
          end else if (needs_operand) begin
            mem_rd   <= 1'b1;
            mem_addr <= x;
            state    <= ST_OPFETCH;
          end else if (alu_onehot != '0) begin
            alu   <= alu_onehot;
            state <= ST_EXEC;
          end else begin
            mem_rd   <= 1'b1;
            mem_addr <= pc;
            state    <= ST_FETCH;
          end
        end

        ST_OPFETCH: begin
          if (mem_ready) begin
            br     <= mem_rdata;
            mem_rd <= 1'b0;
            alu    <= alu_onehot;
            state  <= ST_EXEC;
          end
        end

        ST_EXEC: begin
          mem_rd   <= 1'b1;
          mem_addr <= pc;
          state    <= ST_FETCH;
        end

        ST_STORE: begin
          if (mem_ready) begin
            mem_wr   <= 1'b0;
            mem_rd   <= 1'b1;
            mem_addr <= pc;
            state    <= ST_FETCH;
          end
        end

        ST_HALT: begin
          if (start) begin
            pc       <= '0;
            halted   <= 1'b0;
            mem_addr <= '0;
            mem_rd   <= 1'b1;
            state    <= ST_FETCH;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign IR_out = ir;
  assign BR_out = br;
  assign pc_out = pc;

  assign C8  = alu[C8_IDX];
  assign C9  = alu[C9_IDX];
  assign C13 = alu[C13_IDX];
  assign C15 = alu[C15_IDX];
  assign C16 = alu[C16_IDX];
  assign C17 = alu[C17_IDX];
  assign C18 = alu[C18_IDX];
  assign C19 = alu[C19_IDX];
  assign C20 = alu[C20_IDX];
  assign C21 = alu[C21_IDX];

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: a read-only program memory model and
// one task per scenario, each checking hand-computed values cycle by cycle.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic [15:0] ACC_in;
  logic [3:0]  ALUflags;
  logic [7:0]  mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_wdata;
  logic [15:0] IR_out;
  logic [15:0] BR_out;
  logic        C8, C9, C13, C15, C16, C17, C18, C19, C20, C21;
  logic [7:0]  pc_out;
  logic        halted;
  logic        illegal;

  logic [15:0] mem [0:255];
  logic [9:0]  cvec;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  assign cvec = {C21, C20, C19, C18, C17, C16, C15, C13, C9, C8};

  control_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .ACC_in(ACC_in), .ALUflags(ALUflags),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .IR_out(IR_out), .BR_out(BR_out),
    .C8(C8), .C9(C9), .C13(C13), .C15(C15), .C16(C16), .C17(C17),
    .C18(C18), .C19(C19), .C20(C20), .C21(C21),
    .pc_out(pc_out), .halted(halted), .illegal(illegal)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask

  task automatic do_reset;
    rst_n = 1'b1; start = 1'b0; mem_ready = 1'b1;
    tick; tick;
    rst_n = 1'b0;
    tick;
  endtask

  // Leaves the bench one cycle into FETCH (cycle 1).
  task automatic pulse_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b1; start = 1'b0; mem_ready = 1'b1; ACC_in = 16'h0; ALUflags = 4'h0;
    tick; tick;
    vectors++; if (mem_addr !== 8'h00) begin miscompares++; $display("FAIL reset_addr: got %h want 00", mem_addr); end
    vectors++; if (mem_rd !== 1'b0) begin miscompares++; $display("FAIL reset_rd: got %b want 0", mem_rd); end
    vectors++; if (mem_wr !== 1'b0) begin miscompares++; $display("FAIL reset_wr: got %b want 0", mem_wr); end
    vectors++; if (mem_wdata !== 16'h0) begin miscompares++; $display("FAIL reset_wdata: got %h want 0000", mem_wdata); end
    vectors++; if (IR_out !== 16'h0) begin miscompares++; $display("FAIL reset_ir: got %h want 0000", IR_out); end
    vectors++; if (BR_out !== 16'h0) begin miscompares++; $display("FAIL reset_br: got %h want 0000", BR_out); end
    vectors++; if (cvec !== 10'h0) begin miscompares++; $display("FAIL reset_c: got %h want 000", cvec); end
    vectors++; if (pc_out !== 8'h00) begin miscompares++; $display("FAIL reset_pc: got %h want 00", pc_out); end
    vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL reset_halted: got %b want 0", halted); end
    vectors++; if (illegal !== 1'b0) begin miscompares++; $display("FAIL reset_illegal: got %b want 0", illegal); end
    rst_n = 1'b0;
    tick;
    $display("reset: outputs checked while held");
  endtask

  task automatic test_add;
    do_reset; clear_mem;
    mem[8'h00] = 16'h0310; mem[8'h10] = 16'h0005;
    pulse_start;
    vectors++; if (mem_rd !== 1'b1 || mem_addr !== 8'h00) begin miscompares++; $display("FAIL add_fetch: rd=%b addr=%h want rd=1 addr=00", mem_rd, mem_addr); end
    tick;
    vectors++; if (IR_out !== 16'h0310 || pc_out !== 8'h01) begin miscompares++; $display("FAIL add_decode: ir=%h pc=%h want 0310/01", IR_out, pc_out); end
    vectors++; if (cvec !== 10'h0) begin miscompares++; $display("FAIL add_c_decode: got %h want 000", cvec); end
    tick;
    vectors++; if (mem_rd !== 1'b1 || mem_addr !== 8'h10 || cvec !== 10'h0) begin miscompares++; $display("FAIL add_opfetch: rd=%b addr=%h c=%h want 1/10/000", mem_rd, mem_addr, cvec); end
    tick;
    vectors++; if (cvec !== 10'h001) begin miscompares++; $display("FAIL add_exec_c8: got %h want 001", cvec); end
    vectors++; if (BR_out !== 16'h0005 || pc_out !== 8'h01) begin miscompares++; $display("FAIL add_exec_br: br=%h pc=%h want 0005/01", BR_out, pc_out); end
    tick;
    vectors++; if (cvec !== 10'h0 || mem_rd !== 1'b1 || mem_addr !== 8'h01) begin miscompares++; $display("FAIL add_next_fetch: c=%h rd=%b addr=%h want 000/1/01", cvec, mem_rd, mem_addr); end
    $display("add 0x0310: BR=%h C8 pulse checked", BR_out);
  endtask

  task automatic test_store;
    do_reset; clear_mem;
    mem[8'h00] = 16'h0120; ACC_in = 16'h1234;
    pulse_start; tick; tick;
    ACC_in = 16'hBEEF;
    vectors++; if (mem_wr !== 1'b1 || mem_rd !== 1'b0) begin miscompares++; $display("FAIL store_req: wr=%b rd=%b want 1/0", mem_wr, mem_rd); end
    vectors++; if (mem_addr !== 8'h20 || mem_wdata !== 16'h1234) begin miscompares++; $display("FAIL store_data: addr=%h wdata=%h want 20/1234", mem_addr, mem_wdata); end
    vectors++; if (cvec !== 10'h0) begin miscompares++; $display("FAIL store_c: got %h want 000", cvec); end
    tick;
    vectors++; if (mem_wr !== 1'b0 || mem_rd !== 1'b1 || mem_addr !== 8'h01) begin miscompares++; $display("FAIL store_done: wr=%b rd=%b addr=%h want 0/1/01", mem_wr, mem_rd, mem_addr); end
    $display("store 0x0120: wrote ACC to 0x20");
  endtask

  task automatic test_cond_jump;
    logic [15:0] instr [6];
    logic [3:0]  flg   [6];
    logic [7:0]  exp_a [6];
    instr = '{16'h0930, 16'h0930, 16'h0530, 16'h0530, 16'h0640, 16'h0000};
    flg   = '{4'b1000,  4'b0000,  4'b0001,  4'b0000,  4'b0000,  4'b1111};
    exp_a = '{8'h30,    8'h01,    8'h01,    8'h30,    8'h40,    8'h01};
    for (int v = 0; v < 6; v++) begin
      do_reset; clear_mem;
      mem[8'h00] = instr[v]; ALUflags = flg[v];
      pulse_start; tick; tick;
      vectors++; if (mem_rd !== 1'b1 || mem_addr !== exp_a[v]) begin miscompares++; $display("FAIL jump_%0d: rd=%b addr=%h want 1/%h", v, mem_rd, mem_addr, exp_a[v]); end
      vectors++; if (pc_out !== exp_a[v] || cvec !== 10'h0) begin miscompares++; $display("FAIL jump_pc_%0d: pc=%h c=%h want %h/000", v, pc_out, cvec, exp_a[v]); end
      $display("jump instr=%h flags=%b -> fetch %h", instr[v], flg[v], mem_addr);
    end
    ALUflags = 4'h0;
  endtask

  task automatic test_wait_states;
    do_reset; clear_mem;
    mem[8'h00] = 16'h0410; mem[8'h10] = 16'h0007;
    mem_ready = 1'b0;
    pulse_start;
    for (int k = 0; k < 3; k++) begin
      vectors++; if (mem_rd !== 1'b1 || mem_addr !== 8'h00 || pc_out !== 8'h00 || cvec !== 10'h0) begin miscompares++; $display("FAIL wait_fetch_%0d: rd=%b addr=%h pc=%h c=%h want 1/00/00/000", k, mem_rd, mem_addr, pc_out, cvec); end
      tick;
    end
    mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0;
    vectors++; if (IR_out !== 16'h0410 || pc_out !== 8'h01) begin miscompares++; $display("FAIL wait_decode: ir=%h pc=%h want 0410/01", IR_out, pc_out); end
    tick;
    for (int k = 0; k < 3; k++) begin
      vectors++; if (mem_rd !== 1'b1 || mem_addr !== 8'h10 || BR_out !== 16'h0 || cvec !== 10'h0) begin miscompares++; $display("FAIL wait_opfetch_%0d: rd=%b addr=%h br=%h c=%h want 1/10/0000/000", k, mem_rd, mem_addr, BR_out, cvec); end
      tick;
    end
    mem_ready = 1'b1;
    tick;
    vectors++; if (cvec !== 10'h002 || BR_out !== 16'h0007) begin miscompares++; $display("FAIL wait_exec: c=%h br=%h want 002/0007", cvec, BR_out); end
    $display("sub with wait states: BR=%h", BR_out);
  endtask

  task automatic test_halt_illegal;
    do_reset; clear_mem;
    mem[8'h00] = 16'h0700;
    pulse_start; tick; tick;
    vectors++; if (halted !== 1'b1 || illegal !== 1'b0) begin miscompares++; $display("FAIL halt_state: halted=%b illegal=%b want 1/0", halted, illegal); end
    for (int k = 0; k < 3; k++) begin
      vectors++; if (mem_rd !== 1'b0 || mem_wr !== 1'b0) begin miscompares++; $display("FAIL halt_quiet_%0d: rd=%b wr=%b want 0/0", k, mem_rd, mem_wr); end
      tick;
    end
    mem[8'h00] = 16'h0000;
    pulse_start;
    vectors++; if (halted !== 1'b0 || mem_rd !== 1'b1 || mem_addr !== 8'h00 || pc_out !== 8'h00) begin miscompares++; $display("FAIL halt_restart: halted=%b rd=%b addr=%h pc=%h want 0/1/00/00", halted, mem_rd, mem_addr, pc_out); end
    $display("halt 0x0700: halted and restarted");

    do_reset; clear_mem;
    mem[8'h00] = 16'hFF00;
    pulse_start; tick; tick;
    vectors++; if (halted !== 1'b1 || illegal !== 1'b1 || mem_rd !== 1'b0) begin miscompares++; $display("FAIL illegal_state: halted=%b illegal=%b rd=%b want 1/1/0", halted, illegal, mem_rd); end
    mem[8'h00] = 16'h0000;
    pulse_start;
    vectors++; if (halted !== 1'b0 || illegal !== 1'b1) begin miscompares++; $display("FAIL illegal_sticky: halted=%b illegal=%b want 0/1", halted, illegal); end
    $display("illegal 0xFF00: sticky flag checked");
  endtask

  task automatic test_wrap;
    do_reset; clear_mem;
    mem[8'h00] = 16'h06FF; mem[8'hFF] = 16'h0000;
    pulse_start; tick; tick;
    vectors++; if (mem_addr !== 8'hFF || pc_out !== 8'hFF) begin miscompares++; $display("FAIL wrap_fetch: addr=%h pc=%h want FF/FF", mem_addr, pc_out); end
    tick;
    vectors++; if (pc_out !== 8'h00) begin miscompares++; $display("FAIL wrap_pc: got %h want 00", pc_out); end
    tick;
    vectors++; if (mem_addr !== 8'h00 || mem_rd !== 1'b1) begin miscompares++; $display("FAIL wrap_next: addr=%h rd=%b want 00/1", mem_addr, mem_rd); end
    $display("wrap: fetch at FF then 00");
  endtask

  task automatic test_reset_mid;
    do_reset; clear_mem;
    mem[8'h00] = 16'h0410; mem[8'h10] = 16'h0001;
    pulse_start; tick; tick; tick;
    vectors++; if (cvec !== 10'h002) begin miscompares++; $display("FAIL mid_pre_c9: got %h want 002", cvec); end
    rst_n = 1'b1;
    #1;
    vectors++; if (C9 !== 1'b0 || mem_rd !== 1'b0 || pc_out !== 8'h00) begin miscompares++; $display("FAIL mid_async: c9=%b rd=%b pc=%h want 0/0/00", C9, mem_rd, pc_out); end
    tick;
    rst_n = 1'b0;
    tick; tick;
    vectors++; if (mem_rd !== 1'b0 || halted !== 1'b0 || IR_out !== 16'h0) begin miscompares++; $display("FAIL mid_idle: rd=%b halted=%b ir=%h want 0/0/0000", mem_rd, halted, IR_out); end
    pulse_start;
    vectors++; if (mem_rd !== 1'b1 || mem_addr !== 8'h00) begin miscompares++; $display("FAIL mid_restart: rd=%b addr=%h want 1/00", mem_rd, mem_addr); end
    $display("reset mid-exec: async clear checked");
  endtask

  task automatic test_back_to_back;
    logic [9:0] exp_c;
    do_reset; clear_mem;
    mem[0] = 16'h0C00; mem[1] = 16'h0D00; mem[2] = 16'h0E00; mem[3] = 16'h0B10;
    mem[4] = 16'h0A10; mem[5] = 16'h0810; mem[6] = 16'h0210; mem[7] = 16'h0700;
    mem[8'h10] = 16'h00F0;
    pulse_start;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      case (cyc)
        3:  exp_c = 10'h010;
        6:  exp_c = 10'h040;
        9:  exp_c = 10'h020;
        13: exp_c = 10'h008;
        17: exp_c = 10'h004;
        21: exp_c = 10'h080;
        25: exp_c = 10'h100;
        default: exp_c = 10'h000;
      endcase
      vectors++; if (cvec !== exp_c) begin miscompares++; $display("FAIL b2b_c_cyc%0d: got %h want %h", cyc, cvec, exp_c); end
      if (mem_rd === 1'b1 && mem_wr === 1'b1) begin miscompares++; $display("FAIL b2b_rdwr_cyc%0d: got rd=1 wr=1 want exclusive", cyc); end
      start = (cyc == 5);
      tick;
      start = 1'b0;
    end
    vectors++; if (halted !== 1'b1 || BR_out !== 16'h00F0 || pc_out !== 8'h08) begin miscompares++; $display("FAIL b2b_end: halted=%b br=%h pc=%h want 1/00F0/08", halted, BR_out, pc_out); end
    $display("back-to-back program: 8 instructions sequenced");
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; mem_ready = 1'b1; ACC_in = 16'h0; ALUflags = 4'h0;
    clear_mem;
    test_reset;
    test_add;
    test_store;
    test_cond_jump;
    test_wait_states;
    test_halt_illegal;
    test_wrap;
    test_reset_mid;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Microsequenced control unit that drives the accumulator/ALU datapath.
- Fetches 16-bit instructions from single-port memory and decodes them.
- Issues the one-hot ALU control lines C8, C9, C13, C15–C21 and consumes the registered ALUflags {ZF,CF,OF,SF}.
- Owns PC, IR, BR and the memory read/write handshake; runs STOREs directly from ACC_in.

Parameters:
- ADDR_W, 8: memory address / PC width.
- DATA_W, 16: instruction and data word width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-high reset (asserted when 1; the name is kept for codebase consistency).
- start  in  1  one-cycle pulse; begins execution at PC=0 from IDLE or HALT.
- mem_rdata  in  16  memory read data, valid when mem_ready=1.
- mem_ready  in  1  memory access complete this cycle.
- ACC_in  in  16  current accumulator value, used for STORE.
- ALUflags  in  4  {ZF,CF,OF,SF} from the accumulator block.
- mem_addr  out  8  memory address.
- mem_rd  out  1  read request.
- mem_wr  out  1  write request.
- mem_wdata  out  16  write data (ACC_in latched at STORE entry).
- IR_out  out  16  instruction register.
- BR_out  out  16  buffer register (operand).
- C8, C9, C13, C15, C16, C17, C18, C19, C20, C21  out  1 each  ALU controls.
- pc_out  out  8  program counter.
- halted  out  1  HALT state indicator.
- illegal  out  1  sticky flag: undefined opcode seen.

Behaviour:
- Reset (async, rst_n=1):
  - Every output is 0; state goes to IDLE.
  - A reset mid-operation drops mem_rd, mem_wr and all C lines immediately, with no clock edge needed.
- Instruction format: opcode = IR[15:8], operand address X = IR[7:0].
- Opcodes and the control line each asserts:
  - 00 NOP.
  - 01 STORE X.
  - 02 LOAD X → C20.
  - 03 ADD X → C8.
  - 04 SUB X → C9.
  - 05 JMPGEZ X: taken if SF=0.
  - 06 JMP X.
  - 07 HALT.
  - 08 MPY X → C19.
  - 09 JZ X: taken if ZF=1.
  - 0A AND X → C13.
  - 0B OR X → C15.
  - 0C NOT → C16.
  - 0D SHR → C18.
  - 0E SHL → C17.
  - Any other opcode: illegal=1, then HALT.
- ALU control lines:
  - At most one C line is high, and only during EXEC, for exactly one cycle.
  - All C lines low means the accumulator holds its value. This matters because the accumulator reloads from the ALU on every clock.
- States:
  - IDLE: wait for start; on start, PC=0 → FETCH.
  - FETCH: mem_rd=1, mem_addr=PC. When mem_ready=1: IR ← mem_rdata, PC ← PC+1 (8-bit wrap, FF→00) → DECODE.
  - DECODE:
    - NOP → FETCH.
    - JMP, or a taken JZ/JMPGEZ: PC ← X → FETCH.
    - Not-taken conditional jump → FETCH.
    - HALT or illegal → HALT.
    - STORE → STORE.
    - NOT/SHR/SHL → EXEC.
    - Every other ALU operation → OPFETCH.
  - OPFETCH: mem_rd=1, mem_addr=X. When mem_ready=1: BR ← mem_rdata → EXEC.
  - EXEC: assert the decoded C line for one cycle → FETCH.
  - STORE: mem_wr=1, mem_addr=X, mem_wdata=ACC_in (latched on entry). When mem_ready=1 → FETCH.
  - HALT: halted=1 and no memory traffic. A start pulse clears PC and halted → FETCH. Only reset clears illegal.
- Memory handshake:
  - Address, read/write request and write data stay stable until mem_ready=1 is sampled.
  - mem_rd and mem_wr are never high together.
  - mem_ready is ignored when no request is active.
- Latency with mem_ready tied high:
  - Operand ALU instruction: 4 cycles.
  - NOT/SHR/SHL: 3 cycles.
  - STORE: 3 cycles.
  - JMP, conditional jump and NOP: 2 cycles.
- Flag timing: conditional jumps sample ALUflags in DECODE. Those flags are the ones registered by the most recent EXEC, which is always at least 2 edges earlier.
- Simultaneous events: start is ignored outside IDLE and HALT. Reset has priority over everything.

Decomposition:
- Package cu_pkg holds:
  - opcode localparams;
  - the state encoding (IDLE, FETCH, DECODE, OPFETCH, EXEC, STORE, HALT);
  - a C-line index map for the 10-bit one-hot ALU vector.
- Sub-module cu_decode (combinational) produces from the opcode:
  - alu_onehot[9:0];
  - needs_operand;
  - is_jump;
  - is_cond;
  - is_store;
  - is_halt;
  - illegal.
- The FSM, PC, IR and BR stay in the top-level module.

Test Plan:
- Reset and ADD: hold rst_n=1 → all outputs 0. Load mem[00]=0x0310, mem[10]=0x0005, pulse start → BR_out=0x0005 and C8 high for exactly one cycle, on the 4th cycle after start; pc_out=0x01.
- STORE: mem[00]=0x0120, ACC_in=0x1234 → one cycle with mem_wr=1, mem_addr=0x20, mem_wdata=0x1234; C lines stay 0.
- Conditional jumps: mem[00]=0x0930.
  - ALUflags=4'b1000 → next FETCH uses mem_addr=0x30.
  - ALUflags=4'b0000 → next FETCH uses mem_addr=0x01.
  - JMPGEZ with SF=1 is not taken.
- Wait states: hold mem_ready=0 for 3 cycles in FETCH and in OPFETCH → mem_rd and mem_addr held stable, PC and BR unchanged, no C line asserted.
- HALT, illegal and wrap:
  - Opcode 0x07 → halted=1, no further mem_rd.
  - Opcode 0xFF → halted=1 and illegal=1.
  - Fetch at PC=0xFF → pc_out wraps to 0x00.
- Reset mid-operation: assert rst_n while C9=1 in EXEC → C9, mem_rd and pc_out are 0 before the next clock edge; state is IDLE after release.
